// File: rtl/stream_fifo_flushable.sv
// stream_fifo_flushable: flushable valid/ready FIFO with optional fall-through.
//   clk_i, rst_i         clock, synchronous active-high reset
//   flush_i              synchronous discard of all stored entries
//   inp_data_i/valid_i   upstream payload and valid; inp_ready_o back to producer
//   oup_data_o/valid_o   downstream payload and valid; oup_ready_i from consumer
//   usage_o              number of stored entries
module stream_fifo_flushable #(
    parameter type         DATA_T       = logic,
    parameter int unsigned DEPTH        = 4,
    parameter bit          FALL_THROUGH = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  DATA_T                      inp_data_i,
    input  logic                       inp_valid_i,
    output logic                       inp_ready_o,
    output DATA_T                      oup_data_o,
    output logic                       oup_valid_o,
    input  logic                       oup_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] usage_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (DEPTH == 0) begin : g_depth_check
        $fatal(1, "stream_fifo_flushable: DEPTH must be >= 1");
    end

    DATA_T         mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          empty, bypass, push, pop;

    assign empty       = count == '0;
    // Ready depends only on stored state, so a pop never opens the input in the same cycle.
    assign inp_ready_o = !rst_i && !flush_i && (count != FULL);
    assign oup_valid_o = !rst_i && !flush_i && (!empty || (FALL_THROUGH && inp_valid_i));
    assign oup_data_o  = (FALL_THROUGH && empty) ? inp_data_i : mem[rd_ptr];
    // A word consumed directly from the input while empty is never stored.
    assign bypass      = FALL_THROUGH && empty && oup_ready_i;
    assign push        = inp_valid_i && inp_ready_o && !bypass;
    assign pop         = oup_valid_o && oup_ready_i && !empty;
    assign usage_o     = count;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= inp_data_i;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule
